// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the sysid ID and timestamp words and reports sticky match/timeout status.
// Optional build macro SYSID_AUTOSTART_EN: start a check automatically after every reset.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1671657548,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE} state_t;

`ifdef SYSID_AUTOSTART_EN
    localparam state_t RESET_STATE = RD_ID;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    // Timer counts from 0 on RD_x entry, so the last allowed cycle holds TIMEOUT_CYCLES-1.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, next_state;
    logic [15:0] timer;
    logic        in_access, timer_expired;
    logic        capture_id, capture_ts, clear_status, set_timeout, timer_clear;

    assign in_access     = (state == RD_ID) || (state == WT_ID) || (state == RD_TS) || (state == WT_TS);
    assign timer_expired = (timer == TIMEOUT_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        next_state   = state;
        capture_id   = 1'b0;
        capture_ts   = 1'b0;
        clear_status = 1'b0;
        set_timeout  = 1'b0;
        timer_clear  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state   = RD_ID;
                    clear_status = 1'b1;
                    timer_clear  = 1'b1;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest && avm_readdatavalid) begin
                    capture_id  = 1'b1;
                    timer_clear = 1'b1;
                    next_state  = RD_TS;
                end else if (timer_expired) begin
                    set_timeout = 1'b1;
                    next_state  = DONE;
                end else if (!avm_waitrequest) begin
                    next_state = WT_ID;
                end
            end
            WT_ID: begin
                if (avm_readdatavalid) begin
                    capture_id  = 1'b1;
                    timer_clear = 1'b1;
                    next_state  = RD_TS;
                end else if (timer_expired) begin
                    set_timeout = 1'b1;
                    next_state  = DONE;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest && avm_readdatavalid) begin
                    capture_ts = 1'b1;
                    next_state = DONE;
                end else if (timer_expired) begin
                    set_timeout = 1'b1;
                    next_state  = DONE;
                end else if (!avm_waitrequest) begin
                    next_state = WT_TS;
                end
            end
            WT_TS: begin
                if (avm_readdatavalid) begin
                    capture_ts = 1'b1;
                    next_state = DONE;
                end else if (timer_expired) begin
                    set_timeout = 1'b1;
                    next_state  = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RESET_STATE;
            timer    <= '0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            state <= next_state;
            if (timer_clear)
                timer <= '0;
            else if (in_access)
                timer <= timer + 16'd1;
            if (clear_status) begin
                id_ok    <= 1'b0;
                ts_ok    <= 1'b0;
                timeout  <= 1'b0;
                id_value <= '0;
                ts_value <= '0;
            end
            if (capture_id) begin
                id_value <= avm_readdata;
                id_ok    <= (avm_readdata == EXPECTED_ID);
            end
            if (capture_ts) begin
                ts_value <= avm_readdata;
                ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            end
            if (set_timeout)
                timeout <= 1'b1;
        end
    end

    // Strobes are masked while reset is held so an autostart reset state never issues a read early.
    assign avm_read    = !reset && ((state == RD_ID) || (state == RD_TS));
    assign avm_address = (state == RD_TS) || (state == WT_TS);
    assign busy        = !reset && in_access;
    assign done        = (state == DONE);
    assign pass        = done && id_ok && ts_ok && !timeout;

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker: a behavioural sysid slave with configurable stall and read latency.
module tb_sysid_checker;

    logic        clock, reset, start;
    logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    localparam logic [31:0] GOOD_ID = 32'd0;
    localparam logic [31:0] GOOD_TS = 32'd1671657548;

    sysid_checker #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
        .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          checks = 0;
    int          errors = 0;
    int          cfg_wait = 0;
    int          cfg_lat = 1;
    bit          cfg_drop_id = 1'b0;
    logic [31:0] cfg_id = GOOD_ID;
    logic [31:0] cfg_ts = GOOD_TS;
    int          spur_req = 0;
    int          accepts = 0;
    int          violations = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Slave model: acts 1 time unit after each falling edge, reading settled DUT outputs.
    initial begin : slave
        int          wait_cnt, pend_cnt, spur_done;
        bit          pend_drop, prev_stall, prev_addr;
        logic [31:0] pend_data, word;
        wait_cnt = 0; pend_cnt = 0; spur_done = 0;
        pend_drop = 0; prev_stall = 0; prev_addr = 0; pend_data = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        forever begin
            @(negedge clock);
            #1;
            avm_readdatavalid = 1'b0;
            avm_waitrequest   = 1'b0;
            if (reset) begin
                wait_cnt = 0; pend_cnt = 0; prev_stall = 0;
            end else begin
                if (prev_stall && !(avm_read && avm_address == prev_addr))
                    violations++;
                prev_stall = 0;
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0 && !pend_drop) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_data;
                    end
                end
                if (spur_done != spur_req) begin
                    spur_done         = spur_req;
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = 32'hDEADBEEF;
                end
                if (!avm_read) begin
                    wait_cnt = 0;
                end else if (wait_cnt < cfg_wait) begin
                    avm_waitrequest = 1'b1;
                    wait_cnt++;
                    prev_stall = 1;
                    prev_addr  = avm_address;
                end else begin
                    wait_cnt = 0;
                    accepts++;
                    word = avm_address ? cfg_ts : cfg_id;
                    if (cfg_lat == 0) begin
                        if (!(cfg_drop_id && !avm_address)) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = word;
                        end
                    end else begin
                        pend_cnt  = cfg_lat;
                        pend_data = word;
                        pend_drop = cfg_drop_id && !avm_address;
                    end
                end
            end
        end
    end

    // Pulses start, optionally pulses it again at cycle restart_at; cyc = first cycle with done=1.
    task automatic run_check(input int restart_at, output int cyc);
        cyc   = -1;
        start = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clock);
            start = (i == restart_at);
            if (done) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clock);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, acc0, viol0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_busy", busy, 0);
        check("rst_read", avm_read, 0);
        check("rst_addr", avm_address, 0);
        check("rst_id_ok", id_ok, 0);
        check("rst_ts_ok", ts_ok, 0);
        check("rst_timeout", timeout, 0);
        check("rst_id_value", id_value, 0);
        check("rst_ts_value", ts_value, 0);
        reset = 1'b0;

`ifdef SYSID_AUTOSTART_EN
        wait_done(cyc);
        check("auto_done_cyc", cyc, 4);
        check("auto_pass", pass, 1);
`else
        spur_req++;
        repeat (3) @(negedge clock);
        check("idle_spur_id_value", id_value, 0);
        check("idle_spur_done", done, 0);
        check("idle_spur_busy", busy, 0);
`endif

        // Matching slave, zero wait, latency 1.
        acc0 = accepts;
        run_check(0, cyc);
        check("match_done_cyc", cyc, 5);
        check("match_pass", pass, 1);
        check("match_id_ok", id_ok, 1);
        check("match_ts_ok", ts_ok, 1);
        check("match_timeout", timeout, 0);
        check("match_ts_value", ts_value, GOOD_TS);
        check("match_reads", accepts - acc0, 2);

        // Timestamp one off.
        cfg_ts = GOOD_TS + 32'd1;
        run_check(0, cyc);
        check("tsbad_done_cyc", cyc, 5);
        check("tsbad_pass", pass, 0);
        check("tsbad_id_ok", id_ok, 1);
        check("tsbad_ts_ok", ts_ok, 0);
        check("tsbad_ts_value", ts_value, 32'd1671657549);
        cfg_ts = GOOD_TS;

        // Three stall cycles per read: 5 + 2*3.
        cfg_wait = 3;
        viol0 = violations;
        run_check(0, cyc);
        check("wait3_done_cyc", cyc, 11);
        check("wait3_pass", pass, 1);

        // Plus one extra latency cycle per read (valid two cycles after acceptance): 5 + 6 + 2.
        cfg_lat = 2;
        run_check(0, cyc);
        check("wait3_lat2_done_cyc", cyc, 13);
        check("wait3_lat2_pass", pass, 1);
        check("stall_read_stable", violations - viol0, 0);
        cfg_wait = 0;

        // Zero-latency fabric: data in the acceptance cycle skips WT_x.
        cfg_lat = 0;
        run_check(0, cyc);
        check("lat0_done_cyc", cyc, 3);
        check("lat0_pass", pass, 1);
        cfg_lat = 1;

        // start pulsed again while busy must not restart the check.
        run_check(2, cyc);
        check("busy_start_done_cyc", cyc, 5);
        check("busy_start_pass", pass, 1);

        // Read never accepted: timeout 8 cycles after RD_ID entry, read dropped in DONE.
        cfg_wait = 1000;
        run_check(0, cyc);
        check("stall_tmo_done_cyc", cyc, 9);
        check("stall_tmo_timeout", timeout, 1);
        check("stall_tmo_pass", pass, 0);
        check("stall_tmo_read", avm_read, 0);
        cfg_wait = 0;

        // ID data never returned.
        cfg_drop_id = 1'b1;
        run_check(0, cyc);
        check("norv_tmo_done_cyc", cyc, 9);
        check("norv_tmo_timeout", timeout, 1);
        check("norv_tmo_pass", pass, 0);
        check("norv_tmo_read", avm_read, 0);
        check("norv_tmo_id_ok", id_ok, 0);
        cfg_drop_id = 1'b0;
        spur_req++;
        repeat (3) @(negedge clock);
        check("done_spur_id_value", id_value, 0);
        check("done_spur_done", done, 1);
        check("done_spur_timeout", timeout, 1);

        // Reset during WT_TS (latency 2 keeps WT_TS at cycles 5-6).
        cfg_lat = 2;
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            start = 1'b0;
        end
        check("mid_busy", busy, 1);
        check("mid_addr", avm_address, 1);
        check("mid_id_ok", id_ok, 1);
        reset = 1'b1;
        @(negedge clock);
        check("postrst_id_ok", id_ok, 0);
        check("postrst_done", done, 0);
        check("postrst_read", avm_read, 0);
        check("postrst_timeout", timeout, 0);
        reset = 1'b0;
        cfg_lat = 1;
`ifdef SYSID_AUTOSTART_EN
        wait_done(cyc);
        check("rerun_done_cyc", cyc, 4);
`else
        repeat (2) @(negedge clock);
        check("postrst_idle_busy", busy, 0);
        run_check(0, cyc);
        check("rerun_done_cyc", cyc, 5);
`endif
        check("rerun_pass", pass, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
